// File: rtl/result_streamer.sv
// result_streamer: streams a burst of signed words from a registered-read result
// memory into a valid/ready sink through a 2-entry fall-through output FIFO.
// A burst is requested with start/base_addr/num_words while idle; busy covers the
// burst and done pulses for one cycle after the final word is accepted.

module result_streamer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0]   CntOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    // Control state
    state_e            state_q;
    logic [ADDR_W:0]   num_q;       // captured burst length
    logic [ADDR_W:0]   issued_q;    // reads issued so far
    logic [ADDR_W:0]   sent_q;      // words accepted by the sink so far
    logic [ADDR_W-1:0] addr_q;      // address of the next read
    logic              busy_q;
    logic              done_q;

    // Read pipeline and output FIFO
    logic              in_flight_q; // mem_data carries a requested word this cycle
    logic [DATA_W-1:0] fifo_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    // Decoded per-cycle events
    logic              accept;
    logic              pop;
    logic              issue;
    logic              last_issue;
    logic [1:0]        occupancy;
    logic [ADDR_W:0]   num_m1;

    // Derive start acceptance, FIFO pop and read-issue decisions for this cycle
    always_comb begin
        num_m1     = num_q - CntOne;
        accept     = (state_q == StIdle) && start && !busy_q;
        pop        = out_valid && out_ready;
        occupancy  = count_q + {1'b0, in_flight_q};
        // Words in flight plus buffered words never exceed the two FIFO slots; a slot
        // being vacated by a pop in this same cycle is already counted as free, which
        // is what keeps the stream gap-free with the sink always ready.
        issue      = (state_q == StRun) &&
                     ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
        last_issue = issue && (issued_q == num_m1);
    end

    // Fall-through FIFO head drives the output stream directly
    always_comb begin
        out_valid = (count_q != 2'd0);
        out_data  = fifo_q[rd_ptr_q];
        out_last  = out_valid && (sent_q == num_m1);
        mem_addr  = addr_q;
        busy      = busy_q;
        done      = done_q;
    end

    // Capture returning read data into the FIFO and track its occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            in_flight_q <= 1'b0;
        end else begin
            if (in_flight_q) begin
                fifo_q[wr_ptr_q] <= mem_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q     <= count_q + {1'b0, in_flight_q} - {1'b0, pop};
            in_flight_q <= issue;
        end
    end

    // Burst sequencing: IDLE -> RUN (issuing reads) -> DRAIN (emptying FIFO) -> IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            num_q    <= '0;
            issued_q <= '0;
            sent_q   <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (issue) begin
                issued_q <= issued_q + CntOne;
                // Park the address on the final read so it stays put afterwards
                if (!last_issue) begin
                    addr_q <= addr_q + AddrOne;
                end
            end
            if (pop) begin
                sent_q <= sent_q + CntOne;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        num_q    <= num_words;
                        issued_q <= '0;
                        sent_q   <= '0;
                        if (num_words == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q  <= base_addr;
                            busy_q  <= 1'b1;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (last_issue) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && out_last) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer: randomized bench with a queue scoreboard. Bursts push the
// words the sink should see (read straight from the memory model) and a negedge
// monitor pops and compares every accepted word.

module tb_result_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  num_words = '0;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem[256];
    int          total = 0;
    int          bad = 0;
    int          words_seen = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    int          ready_mode = 0;
    int          rpat = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_data;
    logic        prev_last;

    result_streamer #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Registered-read result memory
    always @(posedge clk) mem_data <= mem[mem_addr];

    // Sink readiness: 0 = always ready, 1 = 1,0,0,1 pattern, other = random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (rpat == 0) || (rpat == 3);
                rpat = (rpat + 1) % 4;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid) check("valid_implies_busy", 32'(busy), 32'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_data", 32'(out_data), 32'(e.data));
                    check("word_last", 32'(out_last), 32'(e.last));
                    words_seen++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) done_cnt++;
        end
    end

    task automatic fill_random(input logic [7:0] base, input int num);
        for (int i = 0; i < num; i++) begin
            logic [7:0] a;
            a = base + 8'(i);
            mem[a] = 16'($urandom);
        end
    endtask

    // Reference: burst i delivers mem[(base+i) mod 256], last flag on word num-1
    task automatic push_exp(input logic [7:0] base, input int num);
        for (int i = 0; i < num; i++) begin
            logic [7:0] a;
            exp_t e;
            a = base + 8'(i);
            e.data = mem[a];
            e.last = (i == num - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic issue_start(input logic [7:0] base, input int num);
        start     = 1'b1;
        base_addr = base;
        num_words = 9'(num);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for the next done pulse, sampling on negedges
    task automatic wait_done(output int cyc, output bit found);
        cyc = 0;
        found = 0;
        while (cyc < 3000 && !found) begin
            @(negedge clk);
            cyc++;
            if (done) found = 1;
        end
        check("done_seen", 32'(found), 32'd1);
    endtask

    task automatic run_burst(input logic [7:0] base, input int num, input int mode,
                             input bit fixed_data);
        int cyc;
        bit found;
        logic [7:0] alog[$];
        ready_mode = mode;
        if (!fixed_data) fill_random(base, num);
        push_exp(base, num);
        words_seen = 0;
        issue_start(base, num);
        if (num == 0) begin
            @(negedge clk);
            check("zero_done", 32'(done), 32'd1);
            check("zero_busy", 32'(busy), 32'd0);
            check("zero_valid", 32'(out_valid), 32'd0);
            exp_done++;
            @(negedge clk);
            check("zero_done_pulse", 32'(done), 32'd0);
            check("zero_valid2", 32'(out_valid), 32'd0);
            return;
        end
        cyc = 0;
        found = 0;
        while (cyc < 3000 && !found) begin
            @(negedge clk);
            cyc++;
            alog.push_back(mem_addr);
            if (cyc == 1) check("busy_after_start", 32'(busy), 32'd1);
            if (mode == 0 && cyc <= 3) check("first_valid_latency", 32'(out_valid),
                                             32'(cyc == 3));
            if (done) found = 1;
        end
        check("done_seen", 32'(found), 32'd1);
        exp_done++;
        check("busy_at_done", 32'(busy), 32'd0);
        check("valid_at_done", 32'(out_valid), 32'd0);
        check("all_words_out", 32'(exp_q.size()), 32'd0);
        check("word_count", 32'(words_seen), 32'(num));
        if (mode == 0) begin
            check("done_cycle", 32'(cyc), 32'(num + 3));
            for (int n = 1; n <= num + 1 && n <= 20 && n <= alog.size(); n++) begin
                logic [7:0] ea;
                ea = base + 8'((n - 1 < num - 1) ? n - 1 : num - 1);
                check("mem_addr_seq", 32'(alog[n-1]), 32'(ea));
            end
        end
        @(negedge clk);
        check("done_single_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

        // Reset state
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Signed ramp -8..7 at 0x10, sink always ready
        for (int i = 0; i < 16; i++) mem[8'h10 + i] = 16'(i - 8);
        run_burst(8'h10, 16, 0, 1'b1);

        // Address wrap 0xFC..0x03
        run_burst(8'hFC, 8, 0, 1'b0);

        // Back-pressure pattern 1,0,0,1
        run_burst(8'h30, 16, 1, 1'b0);

        // Empty burst
        run_burst(8'h55, 0, 0, 1'b0);

        // Random bursts with random back-pressure
        for (int k = 0; k < 6; k++) begin
            run_burst(8'($urandom), int'($urandom_range(1, 40)), 2, 1'b0);
        end
        run_burst(8'($urandom), 256, 2, 1'b0);
        run_burst(8'h77, 1, 0, 1'b0);

        // start held through a burst, re-accepted in the done cycle
        ready_mode = 2;
        fill_random(8'hA0, 5);
        fill_random(8'hC0, 3);
        push_exp(8'hA0, 5);
        push_exp(8'hC0, 3);
        words_seen = 0;
        start = 1'b1;
        base_addr = 8'hA0;
        num_words = 9'd5;
        @(posedge clk);
        #1;
        base_addr = 8'hC0;
        num_words = 9'd3;
        wait_done(cyc, found);
        check("b2b_first_words", 32'(words_seen), 32'd5);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(cyc, found);
        exp_done += 2;
        check("b2b_words", 32'(words_seen), 32'd8);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);

        // Reset while the 5th word of a 16-word burst is at the head
        ready_mode = 0;
        fill_random(8'h40, 16);
        mem[8'h44] = 16'hBEEF;
        push_exp(8'h40, 16);
        words_seen = 0;
        issue_start(8'h40, 16);
        cyc = 0;
        while (words_seen < 4 && cyc < 200) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check("abort_point", 32'(words_seen), 32'd4);
        check("abort_head_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", 32'(out_data), 32'd0);
        check("abort_last", 32'(out_last), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("no_done_after_abort", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        run_burst(8'h20, 1, 0, 1'b0);

        check("done_pulse_count", 32'(done_cnt), 32'(exp_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
